ext_sram_mp: RTL and testbench

Parametrised behavioural model of the external SRAM used in conv simulation benches. It has one write channel with byte strobes and NRD independent read channels. Each channel has a programmable fixed access latency and a valid/ready handshake. It generalises the single-read/single-write fixed-width model with:
- configurable width, depth and read-channel count
- request capture at acceptance
- abort on valid drop
- registered read data
- defined collision ordering

---
 rtl/ext_sram_mp.sv | 209 ++++++++++++++++++++
 tb/tb_ext_sram_mp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_sram_mp.sv
// ---------------------------------------------------------------------------
// ext_sram_mp : behavioural external SRAM with one byte-strobed write channel
// and NRD independent read channels, each with a fixed access latency.
//
// Ports:
//   clk      in   single clock for all channels
//   rst_n    in   asynchronous active-low reset
//   w_valid  in   write request, held high until w_ready
//   w_addr   in   write word address
//   w_data   in   write data
//   w_strb   in   byte enables, bit i covers data[8i+7:8i]
//   w_ready  out  one-cycle write completion pulse
//   r_valid  in   per-channel read request
//   r_addr   in   packed read addresses, channel c at [c*ADDR_W +: ADDR_W]
//   r_data   out  packed registered read data, channel c at [c*DATA_W +: DATA_W]
//   r_ready  out  per-channel one-cycle read completion pulse
//
// Handshake: a channel accepts its request on the first edge (E0) that sees
// valid high while idle and captures address/data/strobe there. Valid must
// stay high through edge E(LAT), where the access happens and ready rises for
// one cycle; dropping valid earlier aborts with no access and no ready. Ready
// clears at E(LAT+1) and a still-high valid is accepted again at E(LAT+2).
// ---------------------------------------------------------------------------

// Per-channel latency FSM shared by the write and read channels.
//   clk, rst_n  clock / async active-low reset
//   i_valid     channel request
//   o_capture   combinational: request accepted on this edge (E0)
//   o_fire      combinational: access happens on this edge (E(LAT))
//   o_ready     registered completion pulse
module ext_sram_mp_chan #(
    parameter int LAT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    output logic o_capture,
    output logic o_fire,
    output logic o_ready
);
    localparam int CNT_W = $clog2(LAT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ready;
    logic             w_ready_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = 1'b0;
        o_capture   = 1'b0;
        o_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    o_capture   = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_valid) begin
                    // Abort: no access, ready stays low.
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(LAT)) begin
                    o_fire      = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Ready was high for this one cycle; return regardless of valid.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_ready = r_ready;
endmodule

module ext_sram_mp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int NRD        = 2,
    parameter int RD_LATENCY = 8,
    parameter int WR_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_valid,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    output logic                  w_ready,
    input  logic [NRD-1:0]        r_valid,
    input  logic [NRD*ADDR_W-1:0] r_addr,
    output logic [NRD*DATA_W-1:0] r_data,
    output logic [NRD-1:0]        r_ready
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    // Storage is deliberately not reset; unwritten words read as X.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // ---------------- write channel ----------------
    logic              w_wr_capture;
    logic              w_wr_fire;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [NB-1:0]     r_wr_strb;

    ext_sram_mp_chan #(.LAT(WR_LATENCY)) u_wr_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_valid),
        .o_capture (w_wr_capture),
        .o_fire    (w_wr_fire),
        .o_ready   (w_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
        end else if (w_wr_capture) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
            r_wr_strb <= w_strb;
        end
    end

    // The fire strobe is gated by FSM state, which reset forces to IDLE, so a
    // write pending at reset never reaches the array.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (r_wr_strb[i]) begin
                    r_mem[r_wr_addr][8*i +: 8] <= r_wr_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read channels ----------------
    for (genvar c = 0; c < NRD; c++) begin : g_rd
        logic              w_rd_capture;
        logic              w_rd_fire;
        logic [ADDR_W-1:0] r_rd_addr;
        logic [DATA_W-1:0] r_rd_data;

        ext_sram_mp_chan #(.LAT(RD_LATENCY)) u_rd_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_valid   (r_valid[c]),
            .o_capture (w_rd_capture),
            .o_fire    (w_rd_fire),
            .o_ready   (r_ready[c])
        );

        // Reads sample the array with the same edge as any write, so a read
        // completing together with a write to its address returns old data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_addr <= '0;
                r_rd_data <= '0;
            end else begin
                if (w_rd_capture) begin
                    r_rd_addr <= r_addr[c*ADDR_W +: ADDR_W];
                end
                if (w_rd_fire) begin
                    r_rd_data <= r_mem[r_rd_addr];
                end
            end
        end

        assign r_data[c*DATA_W +: DATA_W] = r_rd_data;
    end
endmodule

// File: tb/tb_ext_sram_mp.sv
module tb_ext_sram_mp;
    localparam int DW     = 32;
    localparam int AW     = 16;
    localparam int NRD    = 2;
    localparam int RD_LAT = 8;
    localparam int WR_LAT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_valid;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic [DW/8-1:0]   w_strb;
    logic              w_ready;
    logic [NRD-1:0]    r_valid;
    logic [NRD*AW-1:0] r_addr;
    logic [NRD*DW-1:0] r_data;
    logic [NRD-1:0]    r_ready;

    int checks = 0;
    int errors = 0;

    // Reference memory: a read returns the contents as left by every write
    // that completed strictly before the read's completion edge.
    logic [DW-1:0] mem [int];
    logic [DW-1:0] last_rd [NRD];

    ext_sram_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NRD(NRD),
        .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_valid (w_valid),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .w_strb  (w_strb),
        .w_ready (w_ready),
        .r_valid (r_valid),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .r_ready (r_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Write transaction. abort_after<0 runs to completion; otherwise valid is
    // dropped after edge E(abort_after) and ready must never rise.
    task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input int abort_after);
        @(negedge clk);
        w_addr  = a;
        w_data  = d;
        w_strb  = s;
        w_valid = 1'b1;
        for (int k = 0; k <= WR_LAT + 1; k++) begin
            @(posedge clk);
            #1;
            check_eq("wr_ready", DW'(w_ready), DW'(k == WR_LAT));
            if (abort_after >= 0 && k == abort_after) begin
                w_valid = 1'b0;
                for (int j = 0; j < WR_LAT + 2; j++) begin
                    @(posedge clk);
                    #1;
                    check_eq("wr_abort_ready", DW'(w_ready), '0);
                end
                return;
            end
            if (k == 1) begin
                // Inputs after acceptance must be ignored.
                w_addr = AW'($urandom);
                w_data = $urandom;
                w_strb = 4'($urandom);
            end
            if (k == WR_LAT) begin
                #2;
                if (!mem.exists(int'(a))) mem[int'(a)] = 'x;
                for (int i = 0; i < DW / 8; i++) begin
                    if (s[i]) mem[int'(a)][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        w_valid = 1'b0;
    endtask

    // Read transaction on channel c; alt is driven on r_addr after E1.
    task automatic rd_txn(input int c, input logic [AW-1:0] a, input logic [AW-1:0] alt,
                          input int abort_after);
        logic [DW-1:0] exp;
        @(negedge clk);
        check_eq("rd_hold_start", r_data[c*DW +: DW], last_rd[c]);
        r_addr[c*AW +: AW] = a;
        r_valid[c]         = 1'b1;
        for (int k = 0; k <= RD_LAT + 1; k++) begin
            @(posedge clk);
            #1;
            check_eq("rd_ready", DW'(r_ready[c]), DW'(k == RD_LAT));
            if (abort_after >= 0 && k == abort_after) begin
                r_valid[c] = 1'b0;
                for (int j = 0; j < RD_LAT + 2; j++) begin
                    @(posedge clk);
                    #1;
                    check_eq("rd_abort_ready", DW'(r_ready[c]), '0);
                end
                check_eq("rd_abort_hold", r_data[c*DW +: DW], last_rd[c]);
                return;
            end
            if (k == 1) r_addr[c*AW +: AW] = alt;
            if (k == RD_LAT) begin
                exp        = mem.exists(int'(a)) ? mem[int'(a)] : 'x;
                last_rd[c] = exp;
                check_eq("rd_data", r_data[c*DW +: DW], exp);
            end
            if (k == RD_LAT + 1) check_eq("rd_data_held", r_data[c*DW +: DW], last_rd[c]);
        end
        r_valid[c] = 1'b0;
    endtask

    function automatic int pick_abort(input int lat);
        return ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
    endfunction

    initial begin
        rst_n   = 1'b0;
        w_valid = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        w_strb  = '0;
        r_valid = '0;
        r_addr  = '0;
        for (int c = 0; c < NRD; c++) last_rd[c] = '0;

        // ---- reset state ----
        #22;
        check_eq("rst_w_ready", DW'(w_ready), '0);
        check_eq("rst_r_ready", DW'(r_ready), '0);
        check_eq("rst_r_data0", r_data[31:0], '0);
        check_eq("rst_r_data1", r_data[63:32], '0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- fill a small working set ----
        for (int a = 0; a < 16; a++) wr_txn(AW'(a), $urandom, 4'hF, -1);

        // ---- write then read latency ----
        wr_txn(16'h0010, 32'hDEADBEEF, 4'hF, -1);
        rd_txn(0, 16'h0010, 16'h0010, -1);
        check_eq("lat_word", r_data[31:0], 32'hDEADBEEF);

        // ---- byte strobe ----
        wr_txn(16'd5, 32'h11223344, 4'hF, -1);
        wr_txn(16'd5, 32'hAABBCCDD, 4'b0101, -1);
        rd_txn(1, 16'd5, 16'd5, -1);
        check_eq("strb_word", r_data[63:32], 32'h11BB33DD);

        // ---- abort ----
        wr_txn(16'd5, 32'hFFFFFFFF, 4'hF, 3);
        rd_txn(0, 16'd5, 16'd5, -1);
        check_eq("abort_word", r_data[31:0], 32'h11BB33DD);
        rd_txn(1, 16'd5, 16'd5, 2);

        // ---- address capture ----
        wr_txn(16'd7, 32'h07070707, 4'hF, -1);
        wr_txn(16'd9, 32'h09090909, 4'hF, -1);
        rd_txn(1, 16'd7, 16'd9, -1);
        check_eq("capture_word", r_data[63:32], 32'h07070707);

        // ---- collision and parallelism ----
        wr_txn(16'd3, 32'h1, 4'hF, -1);
        fork
            wr_txn(16'd3, 32'h5, 4'hF, -1);
            rd_txn(0, 16'd3, 16'd3, -1);
            rd_txn(1, 16'd3, 16'd3, -1);
        join
        check_eq("coll_old0", r_data[31:0], 32'h1);
        check_eq("coll_old1", r_data[63:32], 32'h1);
        rd_txn(0, 16'd3, 16'd3, -1);
        check_eq("coll_new", r_data[31:0], 32'h5);

        // ---- randomized concurrent traffic ----
        for (int it = 0; it < 30; it++) begin
            fork
                begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    wr_txn(AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                           pick_abort(WR_LAT));
                end
                begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    rd_txn(0, AW'($urandom_range(0, 15)), AW'($urandom), pick_abort(RD_LAT));
                end
                begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    rd_txn(1, AW'($urandom_range(0, 15)), AW'($urandom), pick_abort(RD_LAT));
                end
            join
        end

        // ---- reset mid-operation ----
        rd_txn(0, 16'd2, 16'd2, -1);
        rd_txn(1, 16'd16, 16'd16, -1);
        @(negedge clk);
        w_addr  = 16'd2;
        w_data  = 32'hBAD0BAD0;
        w_strb  = 4'hF;
        w_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_w_ready", DW'(w_ready), '0);
        check_eq("midrst_r_ready", DW'(r_ready), '0);
        check_eq("midrst_r_data0", r_data[31:0], '0);
        check_eq("midrst_r_data1", r_data[63:32], '0);
        w_valid = 1'b0;
        for (int c = 0; c < NRD; c++) last_rd[c] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_txn(0, 16'd2, 16'd2, -1);
        wr_txn(16'd2, 32'hC0FFEE02, 4'hF, -1);
        rd_txn(1, 16'd2, 16'd2, -1);
        check_eq("post_rst_word", r_data[63:32], 32'hC0FFEE02);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
